// File: rtl/wb8_pkg.sv
// Shared widths and the arbiter state encoding for the 8-bit Wishbone arbiter.
package wb8_pkg;

    localparam int ADR_W = 24;
    localparam int DAT_W = 8;
    localparam int SEL_W = 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t grant_state(input logic master);
        return master ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/wb8_timeout.sv
// Slave-ack watchdog: counts stalled strobe cycles and pulses expire for one
// cycle when the count equals limit, then restarts from zero.
module wb8_timeout
    import wb8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             count,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign expire = (cnt_reg == limit);

    always_comb begin
        cnt_next = cnt_reg;
        if (expire || clear) begin
            cnt_next = '0;
        end else if (count) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/wb8_arbiter.sv
// Two-master round-robin Wishbone classic arbiter onto one 8-bit slave.
// Optional ack watchdog enabled by defining WB8_ARB_TIMEOUT_EN.
module wb8_arbiter
    import wb8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [0:ADR_W-1] m0_adr_i,
    input  logic [0:DAT_W-1] m0_dat_i,
    input  logic             m0_we_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    input  logic [0:SEL_W-1] m0_sel_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [0:ADR_W-1] m1_adr_i,
    input  logic [0:DAT_W-1] m1_dat_i,
    input  logic             m1_we_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    input  logic [0:SEL_W-1] m1_sel_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [0:DAT_W-1] m_dat_o,
    output logic [0:ADR_W-1] s_adr_o,
    output logic [0:DAT_W-1] s_dat_o,
    output logic             s_we_o,
    output logic [0:SEL_W-1] s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [0:DAT_W-1] s_dat_i,
    input  logic             s_ack_i,
    output logic [0:1]       gnt_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb8_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       last_gnt_reg;
    logic       last_gnt_next;

    logic [0:ADR_W-1] m_adr [2];
    logic [0:DAT_W-1] m_dat [2];
    logic [0:SEL_W-1] m_sel [2];
    logic [1:0]       m_we;
    logic [1:0]       cyc;
    logic [1:0]       stb;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0]       ack;
    logic [1:0]       err;
    logic             sel_m;
    logic             tmo_expire;

    assign m_adr[0] = m0_adr_i;
    assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;
    assign m_dat[1] = m1_dat_i;
    assign m_sel[0] = m0_sel_i;
    assign m_sel[1] = m1_sel_i;
    assign m_we     = {m1_we_i, m0_we_i};
    assign cyc      = {m1_cyc_i, m0_cyc_i};
    assign stb      = {m1_stb_i, m0_stb_i};
    assign req      = cyc & stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                // On a tie the master that did not hold the bus last wins
                if (req[0] && req[1]) begin
                    state_next = grant_state(~last_gnt_reg);
                end else if (req[0]) begin
                    state_next = GNT0;
                end else if (req[1]) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!cyc[0]) begin
                    state_next = req[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!cyc[1]) begin
                    state_next = req[0] ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state_reg && state_next != IDLE) begin
            last_gnt_next = (state_next == GNT1);
        end
    end

    assign gnt[0] = (state_reg == GNT0);
    assign gnt[1] = (state_reg == GNT1);
    // Idle parks the mux on m0 so the address/data lines stay defined
    assign sel_m  = gnt[1];

    always_comb begin
        s_adr_o  = m_adr[sel_m];
        s_dat_o  = m_dat[sel_m];
        s_sel_o  = m_sel[sel_m];
        s_we_o   = m_we[sel_m];
        s_cyc_o  = (|gnt) & cyc[sel_m];
        s_stb_o  = (|gnt) & stb[sel_m] & ~tmo_expire;
        m_dat_o  = s_dat_i;
        gnt_o[0] = gnt[0];
        gnt_o[1] = gnt[1];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign ack[gi] = gnt[gi] & s_ack_i & ~reset;
        assign err[gi] = gnt[gi] & tmo_expire & ~reset;
    end

    assign m0_ack_o = ack[0];
    assign m1_ack_o = ack[1];
    assign m0_err_o = err[0];
    assign m1_err_o = err[1];

`ifdef WB8_ARB_TIMEOUT_EN
    logic tmo_count;

    assign tmo_count = (|gnt) & cyc[sel_m] & stb[sel_m] & ~s_ack_i;

    wb8_timeout u_timeout (
        .clk    (clk),
        .reset  (reset),
        .count  (tmo_count),
        .clear  (~tmo_count),
        .limit  (CNT_W'(TIMEOUT_CYCLES)),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

endmodule

// File: tb/tb_wb8_arbiter.sv
// Scoreboard bench for wb8_arbiter: directed scenarios plus random traffic
// checked against a transaction-level grant/watchdog model.
module tb_wb8_arbiter;

    localparam int TMO = 4;
`ifdef WB8_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [0:23] m_adr [2];
    logic [0:7]  m_dat [2];
    logic [0:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [0:7]  s_dat;
    logic        s_ack;

    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [0:7]  m_dat_o;
    logic [0:23] s_adr_o;
    logic [0:7]  s_dat_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [0:0]  s_sel_o;
    logic [0:1]  gnt_o;

    wb8_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_we_i(m_we[0]),
        .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_sel_i(m_sel[0]),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_we_i(m_we[1]),
        .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_sel_i(m_sel[1]),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .gnt_o(gnt_o)
    );

    typedef struct {
        logic [1:0]  gnt;   // {m1, m0}
        logic [35:0] sbus;
        logic [3:0]  ae;    // {m1_ack, m0_ack, m1_err, m0_err}
        logic [7:0]  mdat;
    } exp_t;

    typedef struct {
        logic [1:0] who;
        logic [7:0] d;
    } ack_t;

    exp_t exp_q [$];
    ack_t ack_q [$];

    int passed = 0;
    int total  = 0;

    // Reference state: owner -1 means nobody holds the bus
    int owner;
    int last;
    int wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnt", 64'({gnt_o[1], gnt_o[0]}), 64'(e.gnt));
            chk("s_bus", 64'({s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o}), 64'(e.sbus));
            chk("ack_err", 64'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 64'(e.ae));
            chk("m_dat", 64'(m_dat_o), 64'(e.mdat));
        end
        if (m0_ack_o || m1_ack_o) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", 64'({m1_ack_o, m0_ack_o}), 64'(0));
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                chk("ack_who", 64'({m1_ack_o, m0_ack_o}), 64'(a.who));
                chk("ack_data", 64'(m_dat_o), 64'(a.d));
            end
        end
    end

    // Predict this cycle's outputs, then advance the model across the edge
    task automatic step();
        exp_t e;
        int   o;
        bit   err_now, a0, a1, stall;
        bit   req [2];
        o       = (owner < 0) ? 0 : owner;
        err_now = TMO_EN && (wd == TMO);
        a0      = (owner == 0) && s_ack && !reset;
        a1      = (owner == 1) && s_ack && !reset;
        e.gnt   = {owner == 1, owner == 0};
        e.sbus  = {m_adr[o], m_dat[o], m_we[o], m_sel[o],
                   (owner >= 0) && m_stb[o] && !err_now,
                   (owner >= 0) && m_cyc[o]};
        e.ae    = {a1, a0, (owner == 1) && err_now && !reset, (owner == 0) && err_now && !reset};
        e.mdat  = s_dat;
        exp_q.push_back(e);
        if (a0) ack_q.push_back('{2'b01, s_dat});
        if (a1) ack_q.push_back('{2'b10, s_dat});

        @(posedge clk);
        req[0] = m_cyc[0] && m_stb[0];
        req[1] = m_cyc[1] && m_stb[1];
        if (reset) begin
            owner = -1; last = 1; wd = 0;
        end else begin
            stall = (owner >= 0) && m_cyc[o] && m_stb[o] && !s_ack;
            if (err_now) wd = 0;
            else if (stall) wd++;
            else wd = 0;
            if (owner < 0) begin
                if (req[0] && req[1]) owner = (last == 1) ? 0 : 1;
                else if (req[0]) owner = 0;
                else if (req[1]) owner = 1;
                if (owner >= 0) last = owner;
            end else if (!m_cyc[owner]) begin
                if (req[1 - owner]) begin
                    owner = 1 - owner;
                    last  = owner;
                end else begin
                    owner = -1;
                end
            end
        end
        #1;
    endtask

    task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                         input logic [0:23] adr, input logic [0:7] dat);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_we[m]  = we;
        m_adr[m] = adr;
        m_dat[m] = dat;
        m_sel[m] = 1'b1;
    endtask

    task automatic slave(input bit ack, input logic [0:7] dat);
        s_ack = ack;
        s_dat = dat;
    endtask

    int blen [2];

    initial begin
        reset = 1'b1;
        set_m(0, 0, 0, 0, 24'h0, 8'h0);
        set_m(1, 0, 0, 0, 24'h0, 8'h0);
        slave(0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        owner = -1; last = 1; wd = 0;

        // Reset state, with a stray ack that must be ignored
        slave(1, 8'h11);
        step();
        reset = 1'b0;
        step();
        slave(0, 8'h00);

        // Single read from m0, slave acks two cycles after the request
        set_m(0, 1, 1, 0, 24'h008000, 8'h00);
        set_m(1, 0, 0, 0, 24'h123456, 8'h77);
        step();
        step();
        slave(1, 8'h5A);
        step();
        slave(0, 8'h00);
        set_m(0, 0, 0, 0, 24'h008000, 8'h00);
        step();
        step();

        // Simultaneous requests: m0 first, zero-bubble handover, next tie to m0
        set_m(0, 1, 1, 1, 24'h000010, 8'hA0);
        set_m(1, 1, 1, 0, 24'h000020, 8'hB0);
        step();
        slave(1, 8'h01);
        step();
        set_m(0, 0, 0, 0, 24'h000010, 8'hA0);
        step();
        slave(1, 8'h02);
        step();
        slave(0, 8'h00);
        set_m(1, 0, 0, 0, 24'h000020, 8'hB0);
        step();
        set_m(0, 1, 1, 0, 24'h000030, 8'hA1);
        set_m(1, 1, 1, 0, 24'h000040, 8'hB1);
        step();
        step();

        // m0 four-beat burst held against a waiting m1
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1, 1, 1, 24'h000100 + 24'(b), 8'(8'hC0 + b));
            slave(1, 8'(8'h40 + b));
            step();
            set_m(0, 1, 0, 1, 24'h000100 + 24'(b), 8'(8'hC0 + b));
            slave(0, 8'h00);
            step();
        end
        set_m(0, 0, 0, 0, 24'h0, 8'h0);
        slave(1, 8'h99);
        step();
        step();
        set_m(1, 0, 0, 0, 24'h0, 8'h0);
        slave(0, 8'h00);
        step();

        // Reset while m1 holds the bus with strobe high
        set_m(1, 1, 1, 0, 24'h00ABCD, 8'h00);
        step();
        step();
        reset = 1'b1;
        slave(1, 8'h33);
        step();
        reset = 1'b0;
        step();
        slave(0, 8'h00);
        set_m(1, 0, 0, 0, 24'h0, 8'h0);
        step();
        step();

        // Slave never acks: watchdog fires when enabled, otherwise m0 just waits
        set_m(0, 1, 1, 0, 24'h00F000, 8'h00);
        for (int i = 0; i < 14; i++) step();
        set_m(0, 0, 0, 0, 24'h0, 8'h0);
        step();

        // Random traffic
        blen[0] = 0;
        blen[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (blen[m] > 0) begin
                    blen[m]--;
                    m_cyc[m] = 1'b1;
                    m_stb[m] = 1'($urandom % 3 != 0);
                end else if ($urandom % 4 == 0) begin
                    blen[m]  = $urandom_range(1, 10);
                    m_cyc[m] = 1'b1;
                    m_stb[m] = 1'b1;
                end else begin
                    m_cyc[m] = 1'b0;
                    m_stb[m] = 1'($urandom % 8 == 0);
                end
                m_adr[m] = 24'($urandom);
                m_dat[m] = 8'($urandom);
                m_we[m]  = 1'($urandom);
                m_sel[m] = 1'($urandom);
            end
            slave(1'($urandom % ((c < 1500) ? 2 : 7) == 0), 8'($urandom));
            reset = 1'($urandom % 250 == 0);
            step();
        end
        reset = 1'b0;
        set_m(0, 0, 0, 0, 24'h0, 8'h0);
        set_m(1, 0, 0, 0, 24'h0, 8'h0);
        slave(0, 8'h00);
        step();

        @(negedge clk);
        #1;
        chk("ack_q_drained", 64'(ack_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
